// File: rtl/kalman_pkg.sv
// Shared Q2.14 fixed-point constants and types for the kalman_core datapath.
// Used by matrix_mul2x2, matrix_inv and the rounding helper.
package kalman_pkg;

  localparam int W     = 16;
  localparam int FRAC  = 14;
  localparam int ACC_W = 34;

  localparam logic [15:0] Q_ONE = 16'h4000;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  localparam int ROUND_HALF = 1 << (FRAC - 1);

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_MAC,
    MM_RND
  } mm_state_e;

endpackage

// File: rtl/q_round_sat.sv
// Round-half-up and saturate a wide fixed-point value to Q2.14.
// Purely combinational; sat flags a clipped result.
module q_round_sat
  import kalman_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = W,
  parameter int FR    = FRAC
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int SW = IN_W + 1;
  localparam logic signed [SW-1:0] HALF =
    SW'(1) <<< (FR - 1);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] t;
  logic                 pos_sat;
  logic                 neg_sat;

  always_comb begin
    sum = SW'(x) + HALF;
    t   = sum >>> FR;
    // Headroom bits must all copy the result sign bit.
    pos_sat = !t[SW-1] && (t[SW-2:OUT_W-1] != '0);
    neg_sat =  t[SW-1] && (t[SW-2:OUT_W-1] != '1);
  end

  always_comb begin
    unique case (1'b1)
      pos_sat: y = {1'b0, {(OUT_W-1){1'b1}}};
      neg_sat: y = {1'b1, {(OUT_W-1){1'b0}}};
      default: y = t[OUT_W-1:0];
    endcase
  end

  assign sat = pos_sat | neg_sat;

endmodule

// File: rtl/matrix_mul2x2.sv
// Sequential 2x2 Q2.14 matrix multiply P = A*B on one shared multiplier.
// start/ready handshake matches matrix_inv so the two chain directly.
module matrix_mul2x2 #(
  parameter int W     = kalman_pkg::W,
  parameter int FRAC  = kalman_pkg::FRAC,
  parameter int ACC_W = kalman_pkg::ACC_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  input  logic signed [W-1:0] e,
  input  logic signed [W-1:0] f,
  input  logic signed [W-1:0] g,
  input  logic signed [W-1:0] h,
  output logic signed [W-1:0] p,
  output logic signed [W-1:0] q,
  output logic signed [W-1:0] r,
  output logic signed [W-1:0] s,
  output logic                overflow,
  output logic                busy,
  output logic                ready
);

  import kalman_pkg::*;

  mm_state_e state_q, state_d;

  logic [2:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] el_q [4];
  logic signed [ACC_W-1:0] el_d [4];
  logic signed [W-1:0]     opa_q [4];
  logic signed [W-1:0]     opa_d [4];
  logic signed [W-1:0]     opb_q [4];
  logic signed [W-1:0]     opb_d [4];
  logic signed [W-1:0]     res_q [4];
  logic signed [W-1:0]     res_d [4];
  logic signed [W-1:0]     rs_y  [4];
  logic [3:0]              rs_sat;
  logic                    ovf_q, ovf_d;
  logic                    rdy_q, rdy_d;

  logic [1:0]              idx;
  logic                    term;
  logic signed [W-1:0]     mul_l, mul_r;
  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_x;

  assign idx  = cnt_q[2:1];
  assign term = cnt_q[0];

  // Row of A picked by idx[1], column of B by idx[0].
  assign mul_l  = opa_q[{idx[1], term}];
  assign mul_r  = opb_q[{term, idx[0]}];
  assign prod   = (2*W)'(mul_l) * (2*W)'(mul_r);
  assign prod_x = ACC_W'(prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MM_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MM_IDLE: if (start) state_d = MM_MAC;
      MM_MAC:  if (cnt_q == 3'd7) state_d = MM_RND;
      MM_RND:  state_d = MM_IDLE;
      default: state_d = MM_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MM_IDLE);
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    el_d  = el_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    ovf_d = ovf_q;
    rdy_d = 1'b0;
    unique case (state_q)
      MM_IDLE: begin
        if (start) begin
          opa_d = '{a, b, c, d};
          opb_d = '{e, f, g, h};
          acc_d = '0;
          cnt_d = '0;
        end
      end
      MM_MAC: begin
        cnt_d = cnt_q + 3'd1;
        if (!term) acc_d = prod_x;
        else       el_d[idx] = acc_q + prod_x;
      end
      MM_RND: begin
        res_d = rs_y;
        ovf_d = |rs_sat;
        rdy_d = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_rs
    q_round_sat #(
      .IN_W  (ACC_W),
      .OUT_W (W),
      .FR    (FRAC)
    ) u_rs (
      .x   (el_q[i]),
      .y   (rs_y[i]),
      .sat (rs_sat[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        el_q[i]  <= '0;
        opa_q[i] <= '0;
        opb_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      el_q  <= el_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      rdy_q <= rdy_d;
    end
  end

  assign p        = res_q[0];
  assign q        = res_q[1];
  assign r        = res_q[2];
  assign s        = res_q[3];
  assign overflow = ovf_q;
  assign ready    = rdy_q;

endmodule

// File: doc/matrix_mul2x2.md
# matrix_mul2x2

Sequential 2x2 signed fixed-point matrix multiplier for the kalman_core datapath. It computes P = A·B on Q2.14 operands using one shared 16x16 multiplier, then rounds and saturates the result back to Q2.14. It uses the same start/ready handshake as the matrix inverter, so the core controller can chain them directly (gain and covariance updates, A·A⁻¹ checks).

## Interface
Parameters:
- W, 16, operand/result width (Q2.14 total bits)
- FRAC, 14, fractional bits of operands and results
- ACC_W, 34, accumulator width (two Q4.28 products plus one guard bit)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- a, b, c, d  in  W each  matrix A = [[a,b],[c,d]], signed Q2.14
- e, f, g, h  in  W each  matrix B = [[e,f],[g,h]], signed Q2.14
- p, q, r, s  out  W each  result P = [[p,q],[r,s]], signed Q2.14, registered
- overflow  out  1  at least one element saturated; valid while ready=1, held until next result
- busy  out  1  high from the cycle after start is accepted until ready
- ready  out  1  one-cycle pulse; p..s and overflow are valid

## Operation
- Reset: state=IDLE. p, q, r, s, overflow, busy, ready all 0. Counter and accumulator cleared.
- FSM states and transitions:
  - IDLE: if start=1, capture a..h into registers, clear acc, cnt=0, go to MAC. Otherwise stay.
  - MAC: cnt runs 0..7. Element index = cnt[2:1] (0=p, 1=q, 2=r, 3=s); term = cnt[0].
  - MAC operand pairs:
    - p: a·e, b·g
    - q: a·f, b·h
    - r: c·e, d·g
    - s: c·f, d·h
  - MAC accumulate: term 0 sets acc = prod. Term 1 writes acc+prod into element register el[idx].
  - MAC exit: after cnt=7, go to RND.
  - RND: for each el, compute t = (el + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up). Saturate t to [-2^(W-1), 2^(W-1)-1]. Register the results into p..s. overflow = OR of the four saturation flags. ready<=1. Go to IDLE.
- Arithmetic widths:
  - Each product is a full 2W-bit signed Q4.28 value.
  - acc is ACC_W signed; a sum of two products can never overflow it.
  - No truncation happens before the RND state.
- start while busy is ignored: it is not queued and has no effect.
- Inputs a..h may change freely after the capture edge.
- Outputs p..s change only on the RND edge and otherwise hold their last value.

## Timing
- Start accepted at edge T0 (IDLE, start=1). MAC occupies edges T1..T8. RND happens at edge T9.
- ready=1 and new p..s are visible in the cycle after T9. ready returns to 0 at T10 unless that cycle also produces a result.
- Latency is 9 cycles from the accepting edge to ready.
- busy=1 from after T0 through the cycle before ready rises.
- Back-to-back: start held high while ready=1 (state is IDLE) is accepted. Throughput is one result per 10 cycles.
- Reset mid-operation aborts immediately. All outputs return to reset values and no ready pulse is issued.
- Boundary cases:
  - -2.0 × -2.0 = +4.0 saturates to 0x7FFF.
  - Values exactly on a half LSB round toward +∞.

## Structure
- Shared kalman_pkg holds the Q2.14 constants: W, FRAC, Q_ONE=16'h4000, Q_MAX=16'h7FFF, Q_MIN=16'h8000, and ROUND_HALF. matrix_inv and this block both use them.
- One natural sub-module is q_round_sat: ACC_W-bit input, W-bit rounded/saturated output plus a sat flag. It is purely combinational.
- Four instances of q_round_sat are used in RND. It is reusable to replace ad-hoc rounding elsewhere in kalman_core.
- A single multiplier is used, with an operand mux on cnt. No DSP duplication.

## Test plan
- Identity: A=[[0x4000,0],[0,0x4000]], B=[[0x1234,0xF000],[0x0800,0x3FFF]] → P=B, overflow=0, ready exactly 9 cycles after the accepting edge, width 1.
- General: A=[[0x4000,0x2000],[0,0x4000]], B=[[0x2000,0],[0x4000,0x2000]] → p=0x4000, q=0x1000, r=0x4000, s=0x2000.
- Saturation:
  - a=b=e=g=0x7FFF, others 0 → p=0x7FFF, overflow=1.
  - a=e=0x8000, others 0 → p=0x7FFF, overflow=1.
  - a=0x8000, e=0x7FFF, b=0x8000, g=0x7FFF → p=0x8000, overflow=1.
- Rounding:
  - a=0x0001, e=0x2000, others 0 → p=0x0001.
  - a=0xFFFF, e=0x2000 → p=0x0000.
  - a=0xFFFF, e=0x6000 → p=0xFFFF.
- Handshake:
  - Pulse start again at T3 → ignored, single ready.
  - Hold start high continuously → a result every 10 cycles.
  - Assert reset at T5 → all outputs 0, no ready.
  - A new start after reset completes normally.
- Chain with matrix_inv: A=[[0x4000,0x2000],[0x1000,0x4000]], feed its inverse as B → P within ±2 LSB of [[0x4000,0],[0,0x4000]].
